// File: rtl/scd.sv
`default_nettype none
// ============================================================================
// Module   : scd
// Purpose  : Shift-count / floating-exponent datapath with step-loop sequencer
// Revision : 1.0
// ============================================================================
module scd #(
  parameter int WIDTH = 10
) (
  input  logic             eboxClk,
  input  logic             eboxReset,
  input  logic [2:0]       CRAM_SCAD,
  input  logic [2:0]       CRAM_SCADA,
  input  logic [1:0]       CRAM_SCADB,
  input  logic [1:0]       CRAM_SC,
  input  logic             CRAM_FEload,
  input  logic [1:0]       CRAM_ARMM,
  input  logic [8:0]       CRAM_MAGIC,
  input  logic             CTL_stepStart,
  input  logic [35:0]      EDP_AR,
  output logic [WIDTH-1:0] SCD_SC,
  output logic [WIDTH-1:0] SCD_FE,
  output logic [WIDTH-1:0] SCD_SCAD,
  output logic             SCD_SCneg,
  output logic             SCD_SCADneg,
  output logic             SCD_SCge36,
  output logic             SCD_stepping,
  output logic             SCD_stepDone,
  output logic [8:0]       SCD_ARMMupper,
  output logic [4:0]       SCD_ARMMlower
);

  localparam logic [0:WIDTH-1] C_ONE  = 1;
  localparam logic [0:WIDTH-1] C_36   = 36;

  // Big-endian views: index 0 is the most significant bit, matching AR[0:35].
  logic [0:35]      ar;
  logic [0:8]       magic;
  logic [0:WIDTH-1] scada, scadb, scad;
  logic [0:WIDTH-1] sc_q, sc_d, fe_q, fe_d;
  logic             stepping_q, stepping_d;
  logic             step_done_q, step_done_d;
  logic             unused_ar;

  assign ar        = EDP_AR;
  assign magic     = CRAM_MAGIC;
  assign unused_ar = ^{ar[12:17], ar[19:26]};

  always_comb begin
    scada = '0;
    case (CRAM_SCADA)
      3'b000:  scada = fe_q;
      3'b001:  scada = {4'b0, ar[0:5]};
      3'b010:  scada = {2'b0, ar[1:8] ^ {8{ar[0]}}};
      3'b011:  scada = {magic[0], magic};
      default: scada = '0;
    endcase

    scadb = '0;
    case (CRAM_SCADB)
      2'b00:   scadb = sc_q;
      2'b01:   scadb = {4'b0, ar[6:11]};
      2'b10:   scadb = {ar[0], ar[0:8]};
      default: scadb = {magic[0], magic};
    endcase

    scad = '0;
    case (CRAM_SCAD)
      3'b000:  scad = scada;
      3'b001:  scad = scada + ~scadb;
      3'b010:  scad = scada + scadb;
      3'b011:  scad = scada - C_ONE;
      3'b100:  scad = scada + C_ONE;
      3'b101:  scad = scada + ~scadb + C_ONE;
      3'b110:  scad = scada | scadb;
      default: scad = scada & scadb;
    endcase
  end

  // A start always wins; an active loop owns SC until it counts out.
  always_comb begin
    sc_d        = sc_q;
    fe_d        = CRAM_FEload ? scad : fe_q;
    stepping_d  = stepping_q;
    step_done_d = 1'b0;
    if (CTL_stepStart) begin
      sc_d = scad;
      if (scad[0] || (scad == '0)) begin
        stepping_d  = 1'b0;
        step_done_d = 1'b1;
      end else begin
        stepping_d  = 1'b1;
      end
    end else if (stepping_q) begin
      sc_d = sc_q - C_ONE;
      if (sc_q == C_ONE) begin
        stepping_d  = 1'b0;
        step_done_d = 1'b1;
      end
    end else begin
      case (CRAM_SC)
        2'b01:   sc_d = scad;
        2'b10:   sc_d = {ar[18], ar[27:35]};
        2'b11:   sc_d = '0;
        default: sc_d = sc_q;
      endcase
    end
  end

  always_ff @(posedge eboxClk) begin
    if (eboxReset) begin
      sc_q        <= '0;
      fe_q        <= '0;
      stepping_q  <= 1'b0;
      step_done_q <= 1'b0;
    end else begin
      sc_q        <= sc_d;
      fe_q        <= fe_d;
      stepping_q  <= stepping_d;
      step_done_q <= step_done_d;
    end
  end

  always_comb begin
    SCD_ARMMupper = magic;
    case (CRAM_ARMM)
      2'b00:   SCD_ARMMupper = magic;
      2'b01:   SCD_ARMMupper = {ar[0], scad[2:9]};
      2'b10:   SCD_ARMMupper = scad[1:9];
      default: SCD_ARMMupper = sc_q[1:9];
    endcase
  end

  assign SCD_ARMMlower = (CRAM_ARMM == 2'b11) ? sc_q[5:9] : magic[4:8];
  assign SCD_SC        = sc_q;
  assign SCD_FE        = fe_q;
  assign SCD_SCAD      = scad;
  assign SCD_SCneg     = sc_q[0];
  assign SCD_SCADneg   = scad[0];
  assign SCD_SCge36    = ~sc_q[0] & (sc_q >= C_36);
  assign SCD_stepping  = stepping_q;
  assign SCD_stepDone  = step_done_q;

endmodule
`default_nettype wire
